// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Brief    : Bit-serial adder controller; runs one full-adder slice over WIDTH
//            cycles, LSB first, behind a start/done handshake.
//            Optional signed-overflow output enabled by SERIAL_ADD_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              C_CW   = $clog2(WIDTH);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

    localparam logic [1:0] C_S_IDLE = 2'd0;
    localparam logic [1:0] C_S_RUN  = 2'd1;
    localparam logic [1:0] C_S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [C_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_last;

    // Shared full-adder slice
    assign w_fa_sum  = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_fa_cout = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_last    = (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= C_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            C_S_IDLE: begin
                if (start) begin
                    w_next = C_S_RUN;
                end
            end
            C_S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = C_S_DONE;
                end
            end
            C_S_DONE: begin
                done   = 1'b1;
                w_next = C_S_IDLE;
            end
            default: begin
                w_next = C_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                C_S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                C_S_RUN: begin
                    r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
                    r_carry <= w_fa_cout;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    // Counter parks at the last index rather than wrapping
                    if (w_last) begin
                        r_cout <= w_fa_cout;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // On the last bit the carry flop holds the carry into the MSB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == C_S_RUN && w_last) begin
            r_ovf <= r_carry ^ w_fa_cout;
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Brief    : Directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int C_W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [C_W-1:0] a;
    logic [C_W-1:0] b;
    logic           cin;
    logic           busy;
    logic           done;
    logic [C_W-1:0] sum;
    logic           cout;
`ifdef SERIAL_ADD_OVF_EN
    logic           ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(C_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample k is taken just after the k-th edge following the accept edge.
    // busy must cover samples 0..7 and done must appear only at sample 8.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, input logic [7:0] esum, input logic ecout,
                          input logic eovf, input int ign_k);
        int nb;
        int nd;
        int dk;
        logic [7:0] dsum;
        logic       dcout;
        logic       dovf;
        nb = 0; nd = 0; dk = -1; dsum = 'x; dcout = 1'bx; dovf = 1'bx;
        a = va; b = vb; cin = vc; start = 1'b1;
        tick();
        start = 1'b0; a = ~va; b = ~vb; cin = ~vc;
        for (int k = 0; k < 12; k++) begin
            if (busy) nb++;
            if (done) begin
                nd++;
                dk = k;
                dsum = sum;
                dcout = cout;
`ifdef SERIAL_ADD_OVF_EN
                dovf = ovf;
`else
                dovf = eovf;
`endif
            end
            if (k == ign_k) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk({tag, "_busy_cycles"}, nb, 8);
        chk({tag, "_done_count"}, nd, 1);
        chk({tag, "_done_pos"}, dk, 8);
        chk({tag, "_sum"}, dsum, esum);
        chk({tag, "_cout"}, dcout, ecout);
        chk({tag, "_sum_hold"}, sum, esum);
        chk({tag, "_ovf"}, dovf, eovf);
    endtask

    initial begin
        int nd;
        int pos [3];
        logic [7:0] dsum [3];
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif

        // Reset wins over a simultaneous start
        start = 1'b1; a = 8'h11; b = 8'h22;
        tick();
        rst_n = 1'b1; start = 1'b0;
        chk("rst_start_busy", busy, 0);
        tick();
        chk("rst_start_busy2", busy, 0);

        run_op("zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, -1);
        run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1);
        run_op("5a_3c", 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1, -1);
        run_op("ignst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 2);
        run_op("ov7f",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1);
        run_op("ov80",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, -1);
        run_op("ovff",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1);

        // Abort mid-RUN with reset
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) nd++;
            tick();
        end
        chk("abort_no_done", nd, 0);
        run_op("post_abort", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, -1);

        // Start held high: accepts every WIDTH+2 cycles
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                if (nd < 3) begin
                    pos[nd] = k;
                    dsum[nd] = sum;
                end
                nd++;
            end
            tick();
        end
        start = 1'b0;
        chk("b2b_count", nd, 3);
        chk("b2b_pos0", pos[0], 8);
        chk("b2b_pos1", pos[1], 18);
        chk("b2b_pos2", pos[2], 28);
        chk("b2b_sum0", dsum[0], 8'h02);
        chk("b2b_sum2", dsum[2], 8'h02);
        chk("b2b_cout", cout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
